// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one outstanding request, fixed LATENCY
// from handshake to data_ok, byte-lane writes committed in the response cycle.
module dmem_responder #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q;
  logic [2:0]              cnt_q;
  logic                    wr_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [3:0]              wstrb_q;
  logic [31:0]             wdata_q;
  logic                    data_ok_q;
  logic [31:0]             rdata_q;

  logic [31:0]             mem [WORDS];

  logic                    hs;
  logic                    enter_resp;
  logic                    rd_wr;
  logic [DEPTH_LOG2-1:0]   addr_idx;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic                    unused_addr_bits;

  assign addr_idx         = addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  // Acceptance is only possible in IDLE; during reset the state sits in IDLE
  // so addr_ok tracks req, but the reset branch below never latches it.
  assign addr_ok = req && (state_q == IDLE);
  assign hs      = addr_ok;

  // The read word is fetched on the edge that enters RESP. With LATENCY=1
  // that edge is the handshake edge itself, so the live request is used.
  assign enter_resp = ((state_q == IDLE) && hs && (LATENCY == 1)) ||
                      ((state_q == BUSY) && (cnt_q == 3'd1));
  assign rd_wr      = (state_q == IDLE) ? wr : wr_q;
  assign rd_idx     = (state_q == IDLE) ? addr_idx : idx_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_ok_q <= enter_resp;
      if (enter_resp && !rd_wr) begin
        rdata_q <= mem[rd_idx];
      end
      case (state_q)
        IDLE: begin
          if (hs) begin
            wr_q    <= wr;
            idx_q   <= addr_idx;
            wstrb_q <= wstrb;
            wdata_q <= wdata;
            if (LATENCY == 1) begin
              state_q <= RESP;
              cnt_q   <= '0;
            end else begin
              state_q <= BUSY;
              cnt_q   <= 3'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory has no reset: contents survive resetn. An aborted write never
  // reaches RESP because reset forces the state back to IDLE.
  always_ff @(posedge clk) begin
    if ((state_q == RESP) && wr_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1/2/7), directed vectors,
// reset and back-to-back sequences, and randomized traffic against a byte-level model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        req_s   [3];
  logic        wr_s    [3];
  logic [31:0] addr_s  [3];
  logic [3:0]  strb_s  [3];
  logic [31:0] wdata_s [3];
  logic        aok_s   [3];
  logic        dok_s   [3];
  logic [31:0] rdata_s [3];

  dmem_responder #(.LATENCY(1), .DEPTH_LOG2(10)) dut0 (
    .clk(clk), .resetn(resetn), .req(req_s[0]), .wr(wr_s[0]), .addr(addr_s[0]),
    .wstrb(strb_s[0]), .wdata(wdata_s[0]), .addr_ok(aok_s[0]), .data_ok(dok_s[0]),
    .rdata(rdata_s[0]));
  dmem_responder #(.LATENCY(2), .DEPTH_LOG2(10)) dut1 (
    .clk(clk), .resetn(resetn), .req(req_s[1]), .wr(wr_s[1]), .addr(addr_s[1]),
    .wstrb(strb_s[1]), .wdata(wdata_s[1]), .addr_ok(aok_s[1]), .data_ok(dok_s[1]),
    .rdata(rdata_s[1]));
  dmem_responder #(.LATENCY(7), .DEPTH_LOG2(4)) dut2 (
    .clk(clk), .resetn(resetn), .req(req_s[2]), .wr(wr_s[2]), .addr(addr_s[2]),
    .wstrb(strb_s[2]), .wdata(wdata_s[2]), .addr_ok(aok_s[2]), .data_ok(dok_s[2]),
    .rdata(rdata_s[2]));

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdata  [int];
  logic [3:0]  mvalid [int];
  logic [31:0] last_rd [3];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 7);
  endfunction

  function automatic int key_of(input int k, input logic [31:0] a);
    int dl;
    dl = (k == 2) ? 4 : 10;
    return k * 65536 + int'((a >> 2) & ((32'd1 << dl) - 32'd1));
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic model_write(input int k, input logic [31:0] a, input logic [3:0] s,
                             input logic [31:0] d);
    int key;
    key = key_of(k, a);
    if (!mdata.exists(key)) begin
      mdata[key]  = '0;
      mvalid[key] = '0;
    end
    mdata[key]  = (mdata[key] & ~lanes(s)) | (d & lanes(s));
    mvalid[key] = mvalid[key] | s;
  endtask

  task automatic chk_read(input string name, input int k, input logic [31:0] a,
                          input logic [31:0] act);
    int key;
    logic [31:0] m;
    key = key_of(k, a);
    if (mdata.exists(key) && (mvalid[key] != 4'd0)) begin
      m = lanes(mvalid[key]);
      chk(name, act & m, mdata[key] & m);
    end
  endtask

  // Caller is positioned between edges with the DUT idle; returns at the
  // same phase one cycle after the response cycle.
  task automatic do_txn(input int k, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d, output logic [31:0] rd);
    int waited;
    logic [31:0] prev;
    waited = 0;
    prev   = last_rd[k];
    rd     = '0;
    req_s[k] = 1'b1; wr_s[k] = w; addr_s[k] = a; strb_s[k] = s; wdata_s[k] = d;
    #1;
    while (!aok_s[k] && waited < 10) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("addr_ok_wait_cycles", 32'(waited), 32'd0);
    if (!aok_s[k]) begin
      req_s[k] = 1'b0;
      return;
    end
    @(posedge clk);
    for (int c = 1; c <= lat_of(k); c++) begin
      @(negedge clk); #1;
      chk("data_ok_timing", 32'(dok_s[k]), 32'(c == lat_of(k)));
      chk("addr_ok_low_busy_resp", 32'(aok_s[k]), 32'd0);
      if (c == lat_of(k)) begin
        rd = rdata_s[k];
        req_s[k] = 1'b0;
      end
    end
    if (w) begin
      model_write(k, a, s, d);
      chk("rdata_hold_in_write_resp", rd, prev);
    end else begin
      last_rd[k] = rd;
    end
    @(negedge clk); #1;
    chk("data_ok_single_cycle", 32'(dok_s[k]), 32'd0);
    chk("rdata_hold_after_resp", rdata_s[k], last_rd[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  localparam bit [5:0] EAOK = 6'b010101;
  localparam bit [5:0] EDOK = 6'b101010;

  initial begin
    vec_t        tbl [12];
    logic [31:0] rd;
    logic [31:0] ba [3];
    bit   [5:0]  eaok;
    bit   [5:0]  edok;

    resetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_s[k] = 1'b0; wr_s[k] = 1'b0; addr_s[k] = '0; strb_s[k] = '0; wdata_s[k] = '0;
      last_rd[k] = '0;
    end

    tbl[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 32'h0000_0020, 4'b1111, 32'h1122_3344, 32'h0};
    tbl[3]  = '{1'b1, 32'h0000_0020, 4'b0100, 32'hAAAA_AAAA, 32'h0};
    tbl[4]  = '{1'b0, 32'h0000_0020, 4'b0000, 32'h0,         32'h11AA_3344};
    tbl[5]  = '{1'b1, 32'h0000_0020, 4'b0000, 32'hFFFF_FFFF, 32'h0};
    tbl[6]  = '{1'b0, 32'h0000_0020, 4'b0000, 32'h0,         32'h11AA_3344};
    tbl[7]  = '{1'b1, 32'h0000_1004, 4'b1111, 32'h0000_0005, 32'h0};
    tbl[8]  = '{1'b0, 32'h0000_0004, 4'b0000, 32'h0,         32'h0000_0005};
    tbl[9]  = '{1'b1, 32'h0000_0030, 4'b1111, 32'h1234_5678, 32'h0};
    tbl[10] = '{1'b1, 32'h0000_0010, 4'b0001, 32'hA5A5_A5A5, 32'h0};
    tbl[11] = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'hDEAD_BEA5};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_data_ok", 32'(dok_s[k]), 32'd0);
      chk("reset_rdata", rdata_s[k], 32'd0);
    end
    req_s[0] = 1'b1;
    #1;
    chk("reset_addr_ok_follows_req", 32'(aok_s[0]), 32'd1);
    @(negedge clk); #1;
    chk("reset_no_handshake", 32'(dok_s[0]), 32'd0);
    req_s[0] = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk); #1;

    // Directed vectors, LATENCY=2
    for (int i = 0; i < 12; i++) begin
      do_txn(1, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, rd);
      if (!tbl[i].w) chk($sformatf("table_read_%0d", i), rd, tbl[i].exp);
    end

    // Reset during BUSY of a write to 0x30
    req_s[1] = 1'b1; wr_s[1] = 1'b1; addr_s[1] = 32'h30; strb_s[1] = 4'hF;
    wdata_s[1] = 32'hBAD0_BAD0;
    #1;
    chk("midrst_addr_ok", 32'(aok_s[1]), 32'd1);
    @(posedge clk);
    @(negedge clk); #1;
    chk("midrst_busy_no_data_ok", 32'(dok_s[1]), 32'd0);
    resetn = 1'b0;
    req_s[1] = 1'b0;
    for (int k = 0; k < 3; k++) last_rd[k] = '0;
    #1;
    chk("midrst_rdata_cleared", rdata_s[1], 32'd0);
    @(negedge clk); #1;
    chk("midrst_in_reset_no_data_ok", 32'(dok_s[1]), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("midrst_dropped_no_data_ok", 32'(dok_s[1]), 32'd0);
    end
    do_txn(1, 1'b0, 32'h30, 4'h0, 32'h0, rd);
    chk("midrst_word_retained", rd, 32'h1234_5678);

    // Back-to-back reads with req held, LATENCY=1
    ba[0] = 32'h40; ba[1] = 32'h44; ba[2] = 32'h48;
    for (int i = 0; i < 3; i++) do_txn(0, 1'b1, ba[i], 4'hF, $urandom, rd);
    eaok = EAOK;
    edok = EDOK;
    req_s[0] = 1'b1; wr_s[0] = 1'b0; addr_s[0] = ba[0];
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("b2b_addr_ok_c%0d", c), 32'(aok_s[0]), 32'(eaok[c]));
      chk($sformatf("b2b_data_ok_c%0d", c), 32'(dok_s[0]), 32'(edok[c]));
      if (dok_s[0]) begin
        chk_read("b2b_rdata", 0, ba[(c - 1) / 2], rdata_s[0]);
        last_rd[0] = rdata_s[0];
      end
      if ((c % 2 == 1) && ((c + 1) / 2 < 3)) addr_s[0] = ba[(c + 1) / 2];
      if (c == 5) req_s[0] = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("b2b_no_extra_data_ok", 32'(dok_s[0]), 32'd0);

    // Randomized traffic on all instances (includes LATENCY=7 sweep and wrap)
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 6; j++) do_txn(k, 1'b1, 32'h100 + 32'(j * 4), 4'hF, $urandom, rd);
      for (int n = 0; n < 30; n++) begin
        logic [31:0] a;
        logic        w;
        a = 32'h100 + 32'($urandom_range(0, 5) * 4);
        a = a | ($urandom << 14) | 32'($urandom_range(0, 3));
        w = 1'($urandom_range(0, 1));
        do_txn(k, w, a, 4'($urandom), $urandom, rd);
        if (!w) chk_read($sformatf("rand_read_k%0d", k), k, a, rd);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
